// File: rtl/sim_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sim_ctrl_if
// Description : Register-bus bundle between a test program (master) and the
//               sim_ctrl status block (slave). One word transfer per cycle:
//               writes are qualified by we_i, reads are combinational on
//               addr_i.
//   we_i   (master->slave) : write strobe
//   addr_i (master->slave) : byte address, ADDR_W bits, bits [1:0] unused
//   data_i (master->slave) : 32-bit write data
//   data_o (slave->master) : 32-bit read data
// Revision    : 1.0 - initial release
// ============================================================================
interface sim_ctrl_if #(
  parameter int ADDR_W = 8
) ();

  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       data_i;
  logic [31:0]       data_o;

  modport master (
    output we_i,
    output addr_i,
    output data_i,
    input  data_o
  );

  modport slave (
    input  we_i,
    input  addr_i,
    input  data_i,
    output data_o
  );

endinterface : sim_ctrl_if
`default_nettype wire

// File: rtl/sim_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sim_ctrl
// Description : Simulation control / status register block. A test program
//               running on the bus starts a test, counts its cycles, and
//               reports PASS or FAIL; an optional watchdog ends a run that
//               takes too long (TMO). Signature registers hold
//               program-computed checksums for the harness to inspect.
//
//   Register map (word aligned, addr_i[1:0] ignored):
//     0x00       CTRL    W    bit0 START, bit1 PASS, bit2 FAIL
//     0x04       STATUS  R    [2:0] state code (IDLE..TMO = 0..4)
//     0x08       TESTNUM R/W  free-form test identifier
//     0x0C       TIMEOUT R/W  watchdog limit in cycles, 0 disables
//     0x10       CYCLES  R    cycles spent in RUN, saturating
//     0x20+4k    SIG[k]  R/W  k < NUM_SIG
//
//   Ports:
//     clk         : clock, all state on rising edge
//     rst         : asynchronous reset, active low
//     bus         : sim_ctrl_if.slave register bus
//     done_o      : test finished (PASS, FAIL or TMO)
//     pass_o      : test finished in PASS
//     tmo_o       : test finished by watchdog
//     test_num_o  : current TESTNUM value
//
//   Build option:
//     SIM_CTRL_WDOG_EN : when defined, the watchdog (TIMEOUT register and
//                        RUN->TMO transition) is built. When undefined,
//                        TIMEOUT reads 0, writes to it are dropped and TMO is
//                        unreachable.
//
//   NUM_SIG must be 1..8 and ADDR_W at least 6 (SIG window reaches 0x3F).
//   ADDR_W must match the ADDR_W of the connected sim_ctrl_if.
// Revision    : 1.0 - initial release
// ============================================================================
module sim_ctrl #(
  parameter int          NUM_SIG     = 4,
  parameter logic [31:0] TIMEOUT_RST = 32'd250,
  parameter int          ADDR_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  sim_ctrl_if.slave   bus,
  output logic        done_o,
  output logic        pass_o,
  output logic        tmo_o,
  output logic [31:0] test_num_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [ADDR_W-1:0] c_ADDR_CTRL    = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] c_ADDR_STATUS  = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] c_ADDR_TESTNUM = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] c_ADDR_TIMEOUT = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] c_ADDR_CYCLES  = ADDR_W'(8'h10);
  localparam logic [3:0]        c_NUM_SIG      = 4'(NUM_SIG);
  localparam logic [31:0]       c_CYCLES_MAX   = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_PASS = 3'd2,
    ST_FAIL = 3'd3,
    ST_TMO  = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_cycles;
  logic [31:0] r_testnum;
  logic [31:0] r_sig [NUM_SIG];
  logic        r_done;
  logic        r_pass;
  logic        r_tmo;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] w_addr;
  logic              w_sig_hit;
  logic [2:0]        w_sig_idx;
  logic              w_sig_ok;
  logic              w_wr_ctrl;
  logic              w_wr_testnum;
  logic              w_wr_sig;
  logic              w_start;
  logic              w_tmo_hit;
  logic [31:0]       w_timeout_rd;
  logic [31:0]       w_sig_rd;
  logic [31:0]       w_rdata;
  logic              w_unused_addr;

  // Byte offset bits are don't-care; forcing them to zero lets every compare
  // below use plain byte addresses.
  assign w_addr        = {bus.addr_i[ADDR_W-1:2], 2'b00};
  assign w_unused_addr = ^bus.addr_i[1:0];

  // SIG window is 0x20..0x3F; entries at or above NUM_SIG behave as unmapped.
  assign w_sig_hit = (w_addr[ADDR_W-1:5] == (ADDR_W-5)'(1));
  assign w_sig_idx = w_addr[4:2];
  assign w_sig_ok  = w_sig_hit && ({1'b0, w_sig_idx} < c_NUM_SIG);

  assign w_wr_ctrl    = bus.we_i && (w_addr == c_ADDR_CTRL);
  assign w_wr_testnum = bus.we_i && (w_addr == c_ADDR_TESTNUM);
  assign w_wr_sig     = bus.we_i && w_sig_ok;

  // START is only meaningful when no run is active; a START bit written
  // during RUN is ignored so it cannot reset the cycle count mid-test.
  assign w_start = w_wr_ctrl && bus.data_i[0] && (r_state != ST_RUN);

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
`ifdef SIM_CTRL_WDOG_EN
  logic [31:0] r_timeout;
  logic        w_wr_timeout;

  assign w_wr_timeout = bus.we_i && (w_addr == c_ADDR_TIMEOUT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timeout <= TIMEOUT_RST;
    end else if (w_wr_timeout) begin
      r_timeout <= bus.data_i;
    end
  end

  // Fires on the edge whose CYCLES increment would land on TIMEOUT, so a
  // limit of N ends the run exactly N cycles after the START edge. At
  // saturation CYCLES+1 wraps to 0, which never matches a non-zero limit.
  assign w_tmo_hit    = (r_timeout != 32'd0) && ((r_cycles + 32'd1) == r_timeout);
  assign w_timeout_rd = r_timeout;
`else
  logic w_unused_tmo_rst;

  assign w_tmo_hit        = 1'b0;
  assign w_timeout_rd     = 32'd0;
  assign w_unused_tmo_rst = ^TIMEOUT_RST;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  // In RUN, FAIL beats PASS, and either explicit verdict beats the watchdog
  // on the same edge. Outside RUN only START is honoured.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_wr_ctrl && bus.data_i[2]) begin
          w_state_nxt = ST_FAIL;
        end else if (w_wr_ctrl && bus.data_i[1]) begin
          w_state_nxt = ST_PASS;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_TMO;
        end
      end
      default: begin
        if (w_start) begin
          w_state_nxt = ST_RUN;
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Status outputs: flopped from the next-state decode so they change on the
  // same edge as the state register and carry no combinational path.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_tmo  <= 1'b0;
    end else begin
      r_done <= (w_state_nxt == ST_PASS) || (w_state_nxt == ST_FAIL) ||
                (w_state_nxt == ST_TMO);
      r_pass <= (w_state_nxt == ST_PASS);
      r_tmo  <= (w_state_nxt == ST_TMO);
    end
  end

  assign done_o     = r_done;
  assign pass_o     = r_pass;
  assign tmo_o      = r_tmo;
  assign test_num_o = r_testnum;

  // --------------------------------------------------------------------------
  // Cycle counter: cleared by START, counts every RUN cycle (including the
  // edge that leaves RUN), saturates, frozen elsewhere.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycles <= 32'd0;
    end else if (w_start) begin
      r_cycles <= 32'd0;
    end else if ((r_state == ST_RUN) && (r_cycles != c_CYCLES_MAX)) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  // --------------------------------------------------------------------------
  // TESTNUM and signature registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_testnum <= 32'd0;
    end else if (w_wr_testnum) begin
      r_testnum <= bus.data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_SIG; k++) begin
        r_sig[k] <= 32'd0;
      end
    end else if (w_wr_sig) begin
      for (int k = 0; k < NUM_SIG; k++) begin
        if (w_sig_idx == 3'(k)) begin
          r_sig[k] <= bus.data_i;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read path (combinational on addr_i)
  // --------------------------------------------------------------------------
  always_comb begin
    w_sig_rd = 32'd0;
    for (int k = 0; k < NUM_SIG; k++) begin
      if (w_sig_idx == 3'(k)) begin
        w_sig_rd = r_sig[k];
      end
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    if (w_sig_ok) begin
      w_rdata = w_sig_rd;
    end else begin
      case (w_addr)
        c_ADDR_STATUS:  w_rdata = {29'd0, r_state};
        c_ADDR_TESTNUM: w_rdata = r_testnum;
        c_ADDR_TIMEOUT: w_rdata = w_timeout_rd;
        c_ADDR_CYCLES:  w_rdata = r_cycles;
        default:        w_rdata = 32'd0;
      endcase
    end
  end

  assign bus.data_o = w_rdata;

endmodule : sim_ctrl
`default_nettype wire

// File: tb/tb_sim_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sim_ctrl
// Description : Self-checking bench for sim_ctrl. A table of one-cycle bus
//               vectors, each carrying the outputs expected while that vector
//               is on the bus (sampled 1 ns before the rising edge, i.e. the
//               effect of all earlier vectors), is driven on falling edges and
//               queued; a monitor pops and compares. Asynchronous reset cases
//               are checked by hand between edges. Build with
//               +define+SIM_CTRL_WDOG_EN to exercise the watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sim_ctrl;

  localparam int          NSIG    = 4;
  localparam logic [31:0] TMO_RST = 32'd250;
`ifdef SIM_CTRL_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif
  localparam logic [31:0] EXP_TMO_RD = WDOG ? TMO_RST : 32'd0;
  localparam logic [7:0]  A_SIGL     = 8'(8'h20 + 4 * (NSIG - 1));
  localparam logic [7:0]  A_SIGX     = 8'(8'h20 + 4 * NSIG);

  // {done, pass, tmo}
  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_PASS = 3'b110;
  localparam logic [2:0] F_FAIL = 3'b100;
  localparam logic [2:0] F_TMO  = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        done;
  logic        pass;
  logic        tmo;
  logic [31:0] tnum;

  sim_ctrl_if #(.ADDR_W(8)) bus ();

  sim_ctrl #(
    .NUM_SIG    (NSIG),
    .TIMEOUT_RST(TMO_RST),
    .ADDR_W     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .done_o    (done),
    .pass_o    (pass),
    .tmo_o     (tmo),
    .test_num_o(tnum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [2:0]  exp_flags;
    logic [31:0] exp_tn;
    string       name;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  vec_t mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t wr(input logic [7:0] a, input logic [31:0] d,
                              input logic [2:0] f, input logic [31:0] tn,
                              input string n);
    vec_t v;
    v.we = 1'b1; v.addr = a; v.wdata = d; v.chk_rd = 1'b0; v.exp_rd = 32'd0;
    v.exp_flags = f; v.exp_tn = tn; v.name = n;
    return v;
  endfunction

  function automatic vec_t rd(input logic [7:0] a, input logic [31:0] e,
                              input logic [2:0] f, input logic [31:0] tn,
                              input string n);
    vec_t v;
    v.we = 1'b0; v.addr = a; v.wdata = 32'd0; v.chk_rd = 1'b1; v.exp_rd = e;
    v.exp_flags = f; v.exp_tn = tn; v.name = n;
    return v;
  endfunction

  task automatic step(input vec_t v);
    @(negedge clk);
    bus.we_i   = v.we;
    bus.addr_i = v.addr;
    bus.data_i = v.wdata;
    sb.push_back(v);
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", n, got, exp);
    end
  endtask

  // Scoreboard monitor: 1 ns before each rising edge.
  always @(negedge clk) begin
    #4;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if ({done, pass, tmo} !== mon_e.exp_flags || tnum !== mon_e.exp_tn) begin
        errors++;
        $display("FAIL %s flags: got done/pass/tmo=%b test_num=%0d, expected %b %0d",
                 mon_e.name, {done, pass, tmo}, tnum, mon_e.exp_flags, mon_e.exp_tn);
      end
      if (mon_e.chk_rd) begin
        checks++;
        if (bus.data_o !== mon_e.exp_rd) begin
          errors++;
          $display("FAIL %s read @0x%02h: got 0x%08h, expected 0x%08h",
                   mon_e.name, mon_e.addr, bus.data_o, mon_e.exp_rd);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global time limit reached");
    $fatal(1, "tb_sim_ctrl time limit");
  end

  initial begin
    // ---------------- vector table ----------------
    vecs.push_back(rd(8'h04, 32'd0,      F_NONE, 0, "reset status"));
    vecs.push_back(rd(8'h0C, EXP_TMO_RD, F_NONE, 0, "reset timeout"));
    vecs.push_back(rd(8'h10, 32'd0,      F_NONE, 0, "reset cycles"));
    vecs.push_back(rd(8'h08, 32'd0,      F_NONE, 0, "write ignored in reset"));
    vecs.push_back(wr(8'h08, 32'd5,      F_NONE, 0, "wr testnum"));
    vecs.push_back(rd(8'h08, 32'd5,      F_NONE, 5, "rd testnum"));
    vecs.push_back(wr(8'h00, 32'd1,      F_NONE, 5, "start"));
    vecs.push_back(rd(8'h04, 32'd1,      F_NONE, 5, "status run"));
    for (int j = 1; j <= 9; j++)
      vecs.push_back(rd(8'h10, 32'(j),   F_NONE, 5, "run cycles"));
    vecs.push_back(wr(8'h00, 32'd2,      F_NONE, 5, "pass write"));
    vecs.push_back(rd(8'h04, 32'd2,      F_PASS, 5, "status pass"));
    vecs.push_back(rd(8'h10, 32'd11,     F_PASS, 5, "cycles at pass"));
    vecs.push_back(rd(8'h10, 32'd11,     F_PASS, 5, "cycles hold"));
    vecs.push_back(wr(8'h00, 32'd4,      F_PASS, 5, "fail bit outside run"));
    vecs.push_back(rd(8'h04, 32'd2,      F_PASS, 5, "still pass"));
    vecs.push_back(rd(8'h00, 32'd0,      F_PASS, 5, "ctrl reads zero"));
    vecs.push_back(wr(8'h00, 32'd1,      F_PASS, 5, "restart from pass"));
    vecs.push_back(rd(8'h10, 32'd0,      F_NONE, 5, "restart cycles"));
    vecs.push_back(rd(8'h04, 32'd1,      F_NONE, 5, "status rerun"));
    vecs.push_back(wr(8'h00, 32'd6,      F_NONE, 5, "fail wins"));
    vecs.push_back(rd(8'h04, 32'd3,      F_FAIL, 5, "status fail"));
    vecs.push_back(wr(8'h00, 32'd7,      F_FAIL, 5, "start+bits from fail"));
    vecs.push_back(rd(8'h04, 32'd1,      F_NONE, 5, "start only applied"));
    vecs.push_back(wr(8'h00, 32'd3,      F_NONE, 5, "pass in run"));
    vecs.push_back(rd(8'h04, 32'd2,      F_PASS, 5, "status pass2"));
    vecs.push_back(wr(A_SIGL, 32'hDEADBEEF, F_PASS, 5, "wr sig last"));
    vecs.push_back(rd(A_SIGL, 32'hDEADBEEF, F_PASS, 5, "rd sig last"));
    vecs.push_back(rd(A_SIGX, 32'd0,        F_PASS, 5, "rd sig beyond"));
    vecs.push_back(wr(A_SIGX, 32'h12345678, F_PASS, 5, "wr sig beyond"));
    vecs.push_back(rd(A_SIGX, 32'd0,        F_PASS, 5, "sig beyond dropped"));
    vecs.push_back(wr(8'h20,  32'hA5A50001, F_PASS, 5, "wr sig0"));
    vecs.push_back(rd(8'h20,  32'hA5A50001, F_PASS, 5, "rd sig0"));
    vecs.push_back(rd(A_SIGL, 32'hDEADBEEF, F_PASS, 5, "sig last kept"));
    vecs.push_back(rd(8'h14,  32'd0,        F_PASS, 5, "unmapped"));
    vecs.push_back(rd(A_SIGL | 8'h02, 32'hDEADBEEF, F_PASS, 5, "addr lsbs ignored"));
    vecs.push_back(wr(8'h0B, 32'd9,      F_PASS, 5, "wr testnum lsbs"));
    vecs.push_back(rd(8'h08, 32'd9,      F_PASS, 9, "rd testnum 9"));
    vecs.push_back(wr(8'h0C, 32'd20,     F_PASS, 9, "wr timeout"));
    vecs.push_back(rd(8'h0C, WDOG ? 32'd20 : 32'd0, F_PASS, 9, "rd timeout"));
    vecs.push_back(wr(8'h00, 32'd1,      F_PASS, 9, "start wdog run"));
    for (int j = 0; j <= 18; j++)
      vecs.push_back(rd(8'h10, 32'(j),   F_NONE, 9, "wdog cycles"));
    vecs.push_back(rd(8'h04, 32'd1,      F_NONE, 9, "before tmo edge"));
    vecs.push_back(rd(8'h04, WDOG ? 32'd4 : 32'd1,   WDOG ? F_TMO : F_NONE, 9, "tmo status"));
    vecs.push_back(rd(8'h10, WDOG ? 32'd20 : 32'd21, WDOG ? F_TMO : F_NONE, 9, "tmo cycles"));
    vecs.push_back(wr(8'h00, 32'd1,      WDOG ? F_TMO : F_NONE, 9, "start from tmo"));
    vecs.push_back(rd(8'h04, 32'd1,      F_NONE, 9, "run before reset"));

    // ---------------- reset phase: writes must be ignored ----------------
    bus.we_i   = 1'b1;
    bus.addr_i = 8'h08;
    bus.data_i = 32'd77;
    #12;
    chk("in reset flags", {29'd0, done, pass, tmo}, 32'd0);
    chk("in reset test_num", tnum, 32'd0);
    @(negedge clk);
    bus.we_i = 1'b0;
    #2 rst = 1'b1;

    foreach (vecs[i]) step(vecs[i]);

    // ---------------- asynchronous reset mid-RUN ----------------
    @(negedge clk);
    bus.we_i   = 1'b0;
    bus.addr_i = 8'h04;
    #2 rst = 1'b0;
    #1;
    chk("async rst flags", {29'd0, done, pass, tmo}, 32'd0);
    chk("async rst test_num", tnum, 32'd0);
    chk("async rst status", bus.data_o, 32'd0);
    bus.addr_i = 8'h0C; #0.5;
    chk("async rst timeout", bus.data_o, EXP_TMO_RD);
    bus.addr_i = 8'h10; #0.5;
    chk("async rst cycles", bus.data_o, 32'd0);
    bus.addr_i = A_SIGL; #0.5;
    chk("async rst sig", bus.data_o, 32'd0);

    // First write on the first edge after release is accepted.
    @(negedge clk);
    bus.we_i   = 1'b1;
    bus.addr_i = 8'h08;
    bus.data_i = 32'd3;
    #2 rst = 1'b1;
    step(rd(8'h08, 32'd3, F_NONE, 3, "first write after release"));
    step(rd(8'h04, 32'd0, F_NONE, 3, "idle after reset"));

    @(negedge clk);
    bus.we_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sim_ctrl
`default_nettype wire
